// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 power-up sequencer.
package oled_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_NEXT,
      ACK,
      STOP,
      GAP
   } state_t;

   localparam int unsigned OLED_INIT_LEN = 25;
   localparam logic [7:0]  OLED_CTRL_CMD = 8'h00;
   localparam int unsigned IDX_W         = 5;

   // Index of the final byte in the stream (address, control, then the ROM).
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OLED_INIT_LEN + 1);

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command list, one byte per index.
module oled_init_rom
   import oled_pkg::*;
(
   input  logic [IDX_W-1:0] index,
   output logic [7:0]       data_c
);

   always_comb begin
      data_c = 8'h00;
      unique case (index)
         5'd0:  data_c = 8'hAE;
         5'd1:  data_c = 8'hD5;
         5'd2:  data_c = 8'h80;
         5'd3:  data_c = 8'hA8;
         5'd4:  data_c = 8'h3F;
         5'd5:  data_c = 8'hD3;
         5'd6:  data_c = 8'h00;
         5'd7:  data_c = 8'h40;
         5'd8:  data_c = 8'h8D;
         5'd9:  data_c = 8'h14;
         5'd10: data_c = 8'h20;
         5'd11: data_c = 8'h00;
         5'd12: data_c = 8'hA1;
         5'd13: data_c = 8'hC8;
         5'd14: data_c = 8'hDA;
         5'd15: data_c = 8'h12;
         5'd16: data_c = 8'h81;
         5'd17: data_c = 8'hCF;
         5'd18: data_c = 8'hD9;
         5'd19: data_c = 8'hF1;
         5'd20: data_c = 8'hDB;
         5'd21: data_c = 8'h40;
         5'd22: data_c = 8'hA4;
         5'd23: data_c = 8'hA6;
         5'd24: data_c = 8'hAF;
         default: data_c = 8'h00;
      endcase
   end

endmodule

// File: rtl/oled_init_sequencer.sv
// Drives the I2C byte engine through one address+control+init-list transaction.
// OLED_SEQ_WATCHDOG_EN adds a per-byte timeout that aborts a stalled transfer.
module oled_init_sequencer
   import oled_pkg::*;
#(
   parameter logic [7:0]  ADDR_BYTE      = 8'h78,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       i2c_enable,
   output logic [7:0] i2c_command,
   output logic       i2c_ack,
   input  logic       i2c_next,
   input  logic       i2c_trouble
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

   if (GAP_CYCLES < 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("oled_init_sequencer: GAP_CYCLES must be >= 8 and TIMEOUT_CYCLES >= 2");
   end

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [GAP_W-1:0] gap, gap_nxt;
   logic             busy_nxt, done_nxt, error_nxt, enable_nxt, ack_nxt;
   logic [7:0]       command_nxt;
   logic [7:0]       rom_data_c;

   // idx holds the byte currently on the bus; the next byte is ROM entry idx-1.
   oled_init_rom u_rom (
      .index  (idx - IDX_W'(1)),
      .data_c (rom_data_c)
   );

`ifdef OLED_SEQ_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd, wd_nxt;
`endif

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idx         <= '0;
         gap         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         i2c_enable  <= 1'b0;
         i2c_ack     <= 1'b0;
         i2c_command <= 8'h00;
`ifdef OLED_SEQ_WATCHDOG_EN
         wd          <= '0;
`endif
      end else begin
         idx         <= idx_nxt;
         gap         <= gap_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         error       <= error_nxt;
         i2c_enable  <= enable_nxt;
         i2c_ack     <= ack_nxt;
         i2c_command <= command_nxt;
`ifdef OLED_SEQ_WATCHDOG_EN
         wd          <= wd_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      gap_nxt     = gap;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      error_nxt   = error;
      enable_nxt  = i2c_enable;
      ack_nxt     = i2c_ack;
      command_nxt = i2c_command;
`ifdef OLED_SEQ_WATCHDOG_EN
      wd_nxt      = wd;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               command_nxt = ADDR_BYTE;
               enable_nxt  = 1'b1;
               busy_nxt    = 1'b1;
               error_nxt   = 1'b0;
               idx_nxt     = '0;
               state_nxt   = WAIT_NEXT;
`ifdef OLED_SEQ_WATCHDOG_EN
               wd_nxt      = '0;
`endif
            end
         end
         WAIT_NEXT: begin
            if (i2c_trouble) begin
               error_nxt = 1'b1;
               ack_nxt   = 1'b0;
               state_nxt = STOP;
            end else if (i2c_next) begin
               if (idx == LAST_IDX) begin
                  state_nxt = STOP;
               end else begin
                  idx_nxt     = idx + IDX_W'(1);
                  command_nxt = (idx == '0) ? OLED_CTRL_CMD : rom_data_c;
                  ack_nxt     = 1'b1;
                  state_nxt   = ACK;
               end
`ifdef OLED_SEQ_WATCHDOG_EN
            end else if (wd == WD_LAST) begin
               error_nxt = 1'b1;
               state_nxt = STOP;
            end else begin
               wd_nxt = wd + WD_W'(1);
`endif
            end
         end
         ACK: begin
            if (i2c_trouble) begin
               error_nxt = 1'b1;
               ack_nxt   = 1'b0;
               state_nxt = STOP;
            end else if (!i2c_next) begin
               ack_nxt   = 1'b0;
               state_nxt = WAIT_NEXT;
`ifdef OLED_SEQ_WATCHDOG_EN
               wd_nxt    = '0;
            end else if (wd == WD_LAST) begin
               error_nxt = 1'b1;
               ack_nxt   = 1'b0;
               state_nxt = STOP;
            end else begin
               wd_nxt = wd + WD_W'(1);
`endif
            end
         end
         STOP: begin
            // Engine closes the bus on its own once enable drops.
            enable_nxt = 1'b0;
            gap_nxt    = GAP_W'(GAP_CYCLES - 1);
            state_nxt  = GAP;
         end
         GAP: begin
            if (gap == '0) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap - GAP_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Self-checking bench: scenario table plus engine model and byte scoreboard.
module tb_oled_init_sequencer;

   localparam int unsigned GAP     = 16;
   localparam int unsigned TIMEOUT = 64;
   localparam int          N_BYTES = 27;
   localparam logic [7:0]  ADDR    = 8'h78;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, error, i2c_enable, i2c_ack;
   logic [7:0] i2c_command;
   logic       i2c_next = 1'b0;
   logic       i2c_trouble = 1'b0;

   oled_init_sequencer #(
      .ADDR_BYTE      (ADDR),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .i2c_enable  (i2c_enable),
      .i2c_command (i2c_command),
      .i2c_ack     (i2c_ack),
      .i2c_next    (i2c_next),
      .i2c_trouble (i2c_trouble)
   );

   always #5 clock = ~clock;

   int pass_cnt = 0;
   int total    = 0;
   int done_cnt = 0;

   logic [7:0] init_bytes [25] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
      8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
      8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

   logic [7:0] exp_q [$];

   typedef struct {
      int dly;
      int hold;
      int trouble_at;
      int reset_at;
      bit poke;
      bit exp_err;
      int exp_bytes;
      int exp_done;
   } vec_t;

   vec_t vecs [6];

   always @(negedge clock) if (done === 1'b1) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [7:0] exp_byte(input int i);
      if (i == 0) return ADDR;
      if (i == 1) return 8'h00;
      return init_bytes[i-2];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},    32'(busy), 32'(0));
      check({tag, "_done"},    32'(done), 32'(0));
      check({tag, "_error"},   32'(error), 32'(0));
      check({tag, "_enable"},  32'(i2c_enable), 32'(0));
      check({tag, "_ack"},     32'(i2c_ack), 32'(0));
      check({tag, "_command"}, 32'(i2c_command), 32'(0));
   endtask

   // Acts as the I2C engine for one frame and checks the controller's handshake.
   task automatic run_frame(input vec_t v);
      int nbytes = 0;
      int d0 = done_cnt;
      bit stopped = 1'b0;
      logic [7:0] exp;
      exp_q.delete();
      for (int i = 0; i < N_BYTES; i++) exp_q.push_back(exp_byte(i));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_on_start",   32'(busy), 32'(1));
      check("enable_on_start", 32'(i2c_enable), 32'(1));
      check("addr_on_start",   32'(i2c_command), 32'(ADDR));
      check("error_cleared",   32'(error), 32'(0));
      while (!stopped) begin
         for (int c = 0; c < v.dly; c++) begin
            start = v.poke && nbytes >= 3 && nbytes <= 5;
            tick();
         end
         start = 1'b0;
         if (nbytes == v.reset_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_reset_values("mid_reset");
            check("mid_reset_done_count", 32'(done_cnt - d0), 32'(v.exp_done));
            check("mid_reset_bytes", 32'(nbytes), 32'(v.exp_bytes));
            exp_q.delete();
            return;
         end
         if (nbytes == v.trouble_at) begin
            i2c_trouble = 1'b1;
            tick();
            i2c_trouble = 1'b0;
            check("error_on_trouble", 32'(error), 32'(1));
            check("ack_low_trouble",  32'(i2c_ack), 32'(0));
            stopped = 1'b1;
         end else begin
            exp = exp_q.pop_front();
            check($sformatf("byte%0d", nbytes), 32'(i2c_command), 32'(exp));
            nbytes++;
            i2c_next = 1'b1;
            tick();
            if (nbytes == N_BYTES) begin
               i2c_next = 1'b0;
               check("ack_low_last", 32'(i2c_ack), 32'(0));
               stopped = 1'b1;
            end else begin
               check($sformatf("ack_rise%0d", nbytes), 32'(i2c_ack), 32'(1));
               check($sformatf("cmd_load%0d", nbytes), 32'(i2c_command), 32'(exp_q[0]));
               for (int h = 0; h < v.hold; h++) begin
                  tick();
                  check("ack_hold", 32'(i2c_ack), 32'(1));
               end
               i2c_next = 1'b0;
               tick();
               check($sformatf("ack_fall%0d", nbytes), 32'(i2c_ack), 32'(0));
            end
         end
      end
      check("enable_in_stop", 32'(i2c_enable), 32'(1));
      tick();
      check("enable_fall", 32'(i2c_enable), 32'(0));
      repeat (GAP - 1) tick();
      check("no_early_done", 32'(done), 32'(0));
      check("busy_in_gap",   32'(busy), 32'(1));
      tick();
      check("done_pulse",  32'(done), 32'(1));
      check("busy_fall",   32'(busy), 32'(0));
      check("final_error", 32'(error), 32'(v.exp_err));
      tick();
      check("done_one_cycle", 32'(done), 32'(0));
      check("byte_count", 32'(nbytes), 32'(v.exp_bytes));
      check("done_count", 32'(done_cnt - d0), 32'(v.exp_done));
      exp_q.delete();
   endtask

   initial begin
      //         dly hold trbl rst poke err bytes done
      vecs[0] = '{36, 0,  -1,  -1, 0,   0,  27,   1};
      vecs[1] = '{36, 3,  -1,  -1, 0,   0,  27,   1};
      vecs[2] = '{36, 0,  10,  -1, 0,   1,  10,   1};
      vecs[3] = '{4,  0,  -1,  -1, 0,   0,  27,   1};
      vecs[4] = '{6,  0,  -1,   5, 0,   0,   5,   0};
      vecs[5] = '{6,  1,  -1,  -1, 1,   0,  27,   1};

      tick();
      tick();
      check_reset_values("por");
      reset = 1'b0;
      tick();

      // Start coincident with reset must be lost.
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      check("start_vs_reset_busy",   32'(busy), 32'(0));
      check("start_vs_reset_enable", 32'(i2c_enable), 32'(0));
      tick();
      check("idle_stays_idle", 32'(busy), 32'(0));

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i]);
         repeat (3) tick();
      end

      // Engine never answers the address byte.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("stall_busy", 32'(busy), 32'(1));
`ifdef OLED_SEQ_WATCHDOG_EN
      begin
         int cyc = 0;
         int d0 = done_cnt;
         while (error !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
         end
         check("wd_error_latency", 32'(cyc), 32'(TIMEOUT));
         cyc = 0;
         while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
         end
         check("wd_done_latency", 32'(cyc), 32'(GAP + 1));
         check("wd_done_error", 32'(error), 32'(1));
         tick();
         check("wd_done_count", 32'(done_cnt - d0), 32'(1));
         check("wd_idle", 32'(busy), 32'(0));
      end
`else
      repeat (200) tick();
      check("stall_busy_held",   32'(busy), 32'(1));
      check("stall_enable_held", 32'(i2c_enable), 32'(1));
      check("stall_no_error",    32'(error), 32'(0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_values("stall_reset");
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
